// File: rtl/div_pkg.sv
// Shared definitions for the restoring divider: default widths, FSM state
// encodings and the magnitude helper used when loading signed operands.
package div_pkg;

    localparam int unsigned DW_DEF = 16;
    localparam int unsigned VW_DEF = 8;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // Magnitude of a sign-extended operand (up to 32 bits). The most-negative
    // value of a narrower width comes back as its unsigned magnitude.
    function automatic logic [31:0] abs_val(input logic signed [31:0] x);
        logic [31:0] r;
        r = x[31] ? 32'(-x) : 32'(x);
        return r;
    endfunction

endpackage

// File: rtl/seq_div_restoring_if.sv
// Divider request/result bundle.
//   master: sequencer side (drives start/dividend/divisor, reads results)
//   slave : divider side   (reads request, drives quotient/remainder/flags)
interface seq_div_restoring_if #(
    parameter int unsigned DW = div_pkg::DW_DEF,
    parameter int unsigned VW = div_pkg::VW_DEF
);
    logic          start;
    logic [DW-1:0] dividend;
    logic [VW-1:0] divisor;
    logic [DW-1:0] quotient;
    logic [VW-1:0] remainder;
    logic          busy;
    logic          done;
    logic          dbz;
    logic          ovf;

    modport master (
        output start, dividend, divisor,
        input  quotient, remainder, busy, done, dbz, ovf
    );

    modport slave (
        input  start, dividend, divisor,
        output quotient, remainder, busy, done, dbz, ovf
    );
endinterface

// File: rtl/div_step.sv
// One combinational restoring-division step.
//   r_i       : partial remainder in (always < divisor)
//   bit_i     : next dividend bit shifted in at the LSB
//   dvs_i     : divisor magnitude
//   r_c_o     : partial remainder out
//   q_bit_c_o : quotient bit produced by this step
module div_step #(
    parameter int unsigned VW = 8
) (
    input  logic [VW-1:0] r_i,
    input  logic          bit_i,
    input  logic [VW-1:0] dvs_i,
    output logic [VW-1:0] r_c_o,
    output logic          q_bit_c_o
);
    logic [VW:0] r_sh;
    logic [VW:0] diff;

    assign r_sh = {r_i, bit_i};
    assign diff = r_sh - {1'b0, dvs_i};

    // r_i < dvs_i means r_sh < 2*dvs_i, so diff fits and its MSB is a clean borrow.
    assign q_bit_c_o = ~diff[VW];
    assign r_c_o     = diff[VW] ? r_sh[VW-1:0] : diff[VW-1:0];
endmodule

// File: rtl/seq_div_restoring.sv
// Multi-cycle restoring divider, one quotient bit per clock.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of seq_div_restoring_if (start/dividend/divisor in;
//           quotient/remainder/busy/done/dbz/ovf out, all registered)
// Accept edge to done: DW+3 cycles, or 3 cycles for divide-by-zero/overflow.
module seq_div_restoring
    import div_pkg::*;
#(
    parameter int unsigned DW     = DW_DEF,
    parameter int unsigned VW     = VW_DEF,
    parameter bit          SIGNED = 1'b1
) (
    input  logic clk,
    input  logic reset,
    seq_div_restoring_if.slave bus
);
    localparam int unsigned CW = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [DW-1:0] MOST_NEG = {1'b1, {(DW-1){1'b0}}};

    logic [2:0]    state_q,   state_d;
    logic [CW-1:0] cnt_q,     cnt_d;
    logic [DW-1:0] dvd_raw_q, dvd_raw_d;
    logic [VW-1:0] dvs_raw_q, dvs_raw_d;
    logic [DW-1:0] shf_q,     shf_d;
    logic [VW-1:0] dvs_q,     dvs_d;
    logic [VW-1:0] rem_q,     rem_d;
    logic          qneg_q,    qneg_d;
    logic          rneg_q,    rneg_d;
    logic          dbz_q,     dbz_d;
    logic          ovf_q,     ovf_d;
    logic          busy_q,    busy_d;
    logic          done_q,    done_d;
    logic [DW-1:0] quot_q,    quot_d;
    logic [VW-1:0] remo_q,    remo_d;

    logic [VW-1:0] step_r;
    logic          step_q;

    // shf_q shifts the dividend out of its MSB while quotient bits enter the LSB.
    div_step #(.VW(VW)) u_step (
        .r_i       (rem_q),
        .bit_i     (shf_q[DW-1]),
        .dvs_i     (dvs_q),
        .r_c_o     (step_r),
        .q_bit_c_o (step_q)
    );

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_raw_d = dvd_raw_q;
        dvs_raw_d = dvs_raw_q;
        shf_d     = shf_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        qneg_d    = qneg_q;
        rneg_d    = rneg_q;
        dbz_d     = dbz_q;
        ovf_d     = ovf_q;
        busy_d    = busy_q;
        done_d    = done_q;
        quot_d    = quot_q;
        remo_d    = remo_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                // First DONE cycle: busy still high, so a start here is ignored.
                if (state_q == S_DONE && busy_q) begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end else if (bus.start) begin
                    state_d   = S_LOAD;
                    dvd_raw_d = bus.dividend;
                    dvs_raw_d = bus.divisor;
                    done_d    = 1'b0;
                    dbz_d     = 1'b0;
                    ovf_d     = 1'b0;
                end
            end

            S_LOAD: begin
                busy_d = 1'b1;
                cnt_d  = '0;
                rem_d  = '0;
                qneg_d = SIGNED && (dvd_raw_q[DW-1] ^ dvs_raw_q[VW-1]);
                rneg_d = SIGNED && dvd_raw_q[DW-1];
                shf_d  = SIGNED ? DW'(abs_val(32'($signed(dvd_raw_q)))) : dvd_raw_q;
                dvs_d  = SIGNED ? VW'(abs_val(32'($signed(dvs_raw_q)))) : dvs_raw_q;
                if (dvs_raw_q == '0) begin
                    dbz_d   = 1'b1;
                    state_d = S_FIX;
                end else if (SIGNED && dvd_raw_q == MOST_NEG && dvs_raw_q == '1) begin
                    ovf_d   = 1'b1;
                    state_d = S_FIX;
                end else begin
                    state_d = S_ITER;
                end
            end

            S_ITER: begin
                shf_d = {shf_q[DW-2:0], step_q};
                rem_d = step_r;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    state_d = S_FIX;
                end
            end

            S_FIX: begin
                // Truncating division: quotient sign = sd^sv, remainder sign = sd.
                if (dbz_q) begin
                    quot_d = '1;
                    remo_d = dvd_raw_q[VW-1:0];
                end else if (ovf_q) begin
                    quot_d = dvd_raw_q;
                    remo_d = '0;
                end else begin
                    quot_d = qneg_q ? (~shf_q) + DW'(1) : shf_q;
                    remo_d = rneg_q ? (~rem_q) + VW'(1) : rem_q;
                end
                state_d = S_DONE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            dvd_raw_q <= '0;
            dvs_raw_q <= '0;
            shf_q     <= '0;
            dvs_q     <= '0;
            rem_q     <= '0;
            qneg_q    <= 1'b0;
            rneg_q    <= 1'b0;
            dbz_q     <= 1'b0;
            ovf_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            quot_q    <= '0;
            remo_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_raw_q <= dvd_raw_d;
            dvs_raw_q <= dvs_raw_d;
            shf_q     <= shf_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            qneg_q    <= qneg_d;
            rneg_q    <= rneg_d;
            dbz_q     <= dbz_d;
            ovf_q     <= ovf_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            quot_q    <= quot_d;
            remo_q    <= remo_d;
        end
    end

    assign bus.quotient  = quot_q;
    assign bus.remainder = remo_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.dbz       = dbz_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_seq_div_restoring.sv
// Self-checking bench for seq_div_restoring: one unsigned and one signed
// instance, a table of directed vectors, handshake/reset corner sequences
// and a random sweep checked against a reference model and the invariant.
module tb_seq_div_restoring;

    typedef struct {
        bit          s;
        logic [15:0] a;
        logic [7:0]  b;
        logic [15:0] q;
        logic [7:0]  r;
        bit          dbz;
        bit          ovf;
        int          lat;
    } vec_t;

    logic clk;
    logic reset;

    int n_vec;
    int n_miss;

    vec_t sb_q[$];
    vec_t tbl[15];

    seq_div_restoring_if #(.DW(16), .VW(8)) ifu ();
    seq_div_restoring_if #(.DW(16), .VW(8)) ifs ();

    seq_div_restoring #(.DW(16), .VW(8), .SIGNED(1'b0)) u_dut_u (
        .clk   (clk),
        .reset (reset),
        .bus   (ifu)
    );

    seq_div_restoring #(.DW(16), .VW(8), .SIGNED(1'b1)) u_dut_s (
        .clk   (clk),
        .reset (reset),
        .bus   (ifs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic cur_done(input bit s);
        return s ? ifs.done : ifu.done;
    endfunction

    function automatic logic cur_busy(input bit s);
        return s ? ifs.busy : ifu.busy;
    endfunction

    task automatic drive(input bit s, input logic st, input logic [15:0] a, input logic [7:0] b);
        if (s) begin
            ifs.start = st; ifs.dividend = a; ifs.divisor = b;
        end else begin
            ifu.start = st; ifu.dividend = a; ifu.divisor = b;
        end
    endtask

    // Reference: SV signed '/' and '%' truncate toward zero, remainder takes dividend sign.
    function automatic vec_t model(input bit s, input logic [15:0] a, input logic [7:0] b);
        vec_t v;
        int sa, sb;
        v.s = s; v.a = a; v.b = b; v.dbz = 1'b0; v.ovf = 1'b0; v.lat = 19;
        if (b == 8'h00) begin
            v.dbz = 1'b1; v.q = 16'hFFFF; v.r = a[7:0]; v.lat = 3;
        end else if (s && a == 16'h8000 && b == 8'hFF) begin
            v.ovf = 1'b1; v.q = a; v.r = 8'h00; v.lat = 3;
        end else if (s) begin
            sa = $signed(a); sb = $signed(b);
            v.q = 16'(sa / sb); v.r = 8'(sa % sb);
        end else begin
            sa = int'(a); sb = int'(b);
            v.q = 16'(sa / sb); v.r = 8'(sa % sb);
        end
        return v;
    endfunction

    // Issue one divide (called at a negedge), optionally pulsing a spurious
    // start 'inject' cycles after accept, then pop the scoreboard and compare.
    task automatic run_div(input vec_t v, input int inject,
                           output logic [15:0] q_o, output logic [7:0] r_o);
        int   lat, bcnt;
        vec_t e;
        sb_q.push_back(v);
        drive(v.s, 1'b1, v.a, v.b);
        @(negedge clk);
        drive(v.s, 1'b0, v.a, v.b);
        chk("done_drop", 32'(cur_done(v.s)), 32'd0);
        lat = 0; bcnt = 0;
        while (!cur_done(v.s) && lat < 100) begin
            if (cur_busy(v.s)) bcnt++;
            if (inject != 0 && lat == inject) drive(v.s, 1'b1, 16'h00C8, 8'h03);
            @(negedge clk);
            lat++;
            drive(v.s, 1'b0, v.s ? ifs.dividend : ifu.dividend, v.s ? ifs.divisor : ifu.divisor);
        end
        e = sb_q.pop_front();
        if (e.s) begin
            q_o = ifs.quotient; r_o = ifs.remainder;
            chk("dbz", 32'(ifs.dbz), 32'(e.dbz));
            chk("ovf", 32'(ifs.ovf), 32'(e.ovf));
        end else begin
            q_o = ifu.quotient; r_o = ifu.remainder;
            chk("dbz", 32'(ifu.dbz), 32'(e.dbz));
            chk("ovf", 32'(ifu.ovf), 32'(e.ovf));
        end
        chk("latency", 32'(lat), 32'(e.lat));
        chk("busy_cycles", 32'(bcnt), 32'(e.lat - 1));
        chk("quotient", 32'(q_o), 32'(e.q));
        chk("remainder", 32'(r_o), 32'(e.r));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] q, a;
        logic [7:0]  r, b;
        bit          s, saw;
        int          sq, sr, sa, sb;
        vec_t        v;

        n_vec = 0; n_miss = 0;

        //             s     a         b      q         r     dbz   ovf   lat
        tbl[0]  = '{1'b0, 16'd100,  8'd7,  16'd14,   8'd2,  1'b0, 1'b0, 19};
        tbl[1]  = '{1'b1, 16'hFF9C, 8'd7,  16'hFFF2, 8'hFE, 1'b0, 1'b0, 19};
        tbl[2]  = '{1'b1, 16'd100,  8'hF9, 16'hFFF2, 8'h02, 1'b0, 1'b0, 19};
        tbl[3]  = '{1'b1, 16'hFF9C, 8'hF9, 16'h000E, 8'hFE, 1'b0, 1'b0, 19};
        tbl[4]  = '{1'b1, 16'd1234, 8'd0,  16'hFFFF, 8'hD2, 1'b1, 1'b0, 3};
        tbl[5]  = '{1'b0, 16'd1234, 8'd0,  16'hFFFF, 8'hD2, 1'b1, 1'b0, 3};
        tbl[6]  = '{1'b1, 16'h8000, 8'hFF, 16'h8000, 8'h00, 1'b0, 1'b1, 3};
        tbl[7]  = '{1'b1, 16'h8000, 8'h80, 16'd256,  8'h00, 1'b0, 1'b0, 19};
        tbl[8]  = '{1'b0, 16'd255,  8'd15, 16'd17,   8'h00, 1'b0, 1'b0, 19};
        tbl[9]  = '{1'b0, 16'hFFFF, 8'h01, 16'hFFFF, 8'h00, 1'b0, 1'b0, 19};
        tbl[10] = '{1'b0, 16'hFFFF, 8'hFF, 16'h0101, 8'h00, 1'b0, 1'b0, 19};
        tbl[11] = '{1'b0, 16'd5,    8'd7,  16'd0,    8'd5,  1'b0, 1'b0, 19};
        tbl[12] = '{1'b1, 16'd0,    8'd5,  16'd0,    8'd0,  1'b0, 1'b0, 19};
        tbl[13] = '{1'b1, 16'h8000, 8'h01, 16'h8000, 8'h00, 1'b0, 1'b0, 19};
        tbl[14] = '{1'b1, 16'h7FFF, 8'h80, 16'hFF01, 8'h7F, 1'b0, 1'b0, 19};

        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 8'h0);
        drive(1'b1, 1'b0, 16'h0, 8'h0);
        repeat (3) @(negedge clk);
        chk("rst_quotient", 32'(ifs.quotient), 32'd0);
        chk("rst_remainder", 32'(ifs.remainder), 32'd0);
        chk("rst_busy_done", 32'({ifs.busy, ifs.done, ifu.busy, ifu.done}), 32'd0);
        chk("rst_flags", 32'({ifs.dbz, ifs.ovf, ifu.dbz, ifu.ovf}), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 15; i++) run_div(tbl[i], 0, q, r);

        // Spurious start five cycles into a divide must be ignored.
        run_div(tbl[0], 5, q, r);

        // Reset in the middle of ITER discards the result with no done pulse.
        drive(1'b1, 1'b1, 16'd100, 8'd7);
        @(negedge clk);
        drive(1'b1, 1'b0, 16'd100, 8'd7);
        repeat (9) @(negedge clk);
        chk("midop_busy", 32'(ifs.busy), 32'd1);
        reset = 1'b1;
        #1;
        chk("midrst_quotient", 32'(ifs.quotient), 32'd0);
        chk("midrst_remainder", 32'(ifs.remainder), 32'd0);
        chk("midrst_busy_done", 32'({ifs.busy, ifs.done}), 32'd0);
        chk("midrst_flags", 32'({ifs.dbz, ifs.ovf}), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        saw = 1'b0;
        repeat (25) begin
            @(negedge clk);
            if (ifs.done) saw = 1'b1;
        end
        chk("no_done_after_reset", 32'(saw), 32'd0);
        run_div('{1'b1, 16'd255, 8'd15, 16'd17, 8'd0, 1'b0, 1'b0, 19}, 0, q, r);

        // Random sweep against the reference model and the division invariant.
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 15) == 0) ? 16'h8000 : 16'($urandom);
            case ($urandom_range(0, 15))
                0:       b = 8'h00;
                1:       b = 8'hFF;
                default: b = 8'($urandom);
            endcase
            v = model(s, a, b);
            run_div(v, 0, q, r);
            if (!v.dbz && !v.ovf) begin
                if (s) begin
                    sq = $signed(q); sr = $signed(r); sa = $signed(a); sb = $signed(b);
                end else begin
                    sq = int'(q); sr = int'(r); sa = int'(a); sb = int'(b);
                end
                chk("invariant", 32'(sq * sb + sr), 32'(sa));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
